// File: rtl/cpu_coherence_ctrl_if.sv
// CPU-side request/response and shared-bus signals of the MSI coherence
// controller. The controller connects through the master modport; the CPU
// model and bus arbiter/memory connect through the slave modport.
interface cpu_coherence_ctrl_if #(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 4
);
  // CPU request channel
  logic               cpu_req;
  logic               cpu_rw;
  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic               cpu_ready;

  // Shared bus channel
  logic                     bus_req;
  logic                     bus_grant;
  logic                     bus_done;
  logic [1:0]               acao;
  logic [TAG_W+INDEX_W-1:0] bus_addr;
  logic                     writeback;

  // State updates coming from this cache's own snoop controller
  logic               snoop_valid;
  logic [INDEX_W-1:0] snoop_index;
  logic [1:0]         snoop_state;

  modport master (
    input  cpu_req, cpu_rw, cpu_index, cpu_tag,
    input  bus_grant, bus_done,
    input  snoop_valid, snoop_index, snoop_state,
    output cpu_ready, bus_req, acao, bus_addr, writeback
  );

  modport slave (
    output cpu_req, cpu_rw, cpu_index, cpu_tag,
    output bus_grant, bus_done,
    output snoop_valid, snoop_index, snoop_state,
    input  cpu_ready, bus_req, acao, bus_addr, writeback
  );
endinterface

// File: rtl/cpu_coherence_ctrl.sv
// Processor-side MSI coherence controller for a small direct-mapped cache.
// Keeps per-line state and tag, classifies CPU accesses as hit or miss,
// issues bus actions (read miss / invalidate / write miss), performs victim
// writeback of exclusive lines and accepts updates from the snoop side.
// Line state: 00 invalid, 01 shared, 10 exclusive.
module cpu_coherence_ctrl #(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  cpu_coherence_ctrl_if.master io
);

  localparam int LINES = 2 ** INDEX_W;

  localparam logic [1:0] ST_INV = 2'b00;
  localparam logic [1:0] ST_SHR = 2'b01;
  localparam logic [1:0] ST_EXC = 2'b10;

  localparam logic [1:0] ACT_READ_MISS  = 2'b00;
  localparam logic [1:0] ACT_INVALIDATE = 2'b01;
  localparam logic [1:0] ACT_WRITE_MISS = 2'b10;
  localparam logic [1:0] ACT_NULL       = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_WAIT,
    BUS_REQ,
    BUS_WAIT,
    DONE
  } ctrlState_e;

  ctrlState_e state_q, state_d;

  // Per-line coherence state and tag
  logic [1:0]       lineState_q [LINES];
  logic [TAG_W-1:0] lineTag_q   [LINES];

  // Latched CPU request and its classification
  logic               reqRw_q;
  logic [INDEX_W-1:0] reqIndex_q;
  logic [TAG_W-1:0]   reqTag_q;
  logic [1:0]         action_q, action_d;
  logic               reqMiss_q, reqMiss_d;

  // Line-array update requests from the FSM
  logic       victimClear;
  logic       commitLine;
  logic [1:0] commitState;

  logic [1:0] curState;
  logic       hit;
  logic       snoopInvalidatesReq;

  assign curState = lineState_q[reqIndex_q];
  assign hit      = (curState != ST_INV) && (lineTag_q[reqIndex_q] == reqTag_q);

  // A snoop invalidating the line we are trying to upgrade means our copy is
  // gone, so the pending invalidate has to become a full write miss.
  assign snoopInvalidatesReq = io.snoop_valid && (io.snoop_index == reqIndex_q) &&
                               (io.snoop_state == ST_INV);

  // FSM state register plus the latched request, action and hit/miss flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      reqRw_q    <= 1'b0;
      reqIndex_q <= '0;
      reqTag_q   <= '0;
      action_q   <= ACT_NULL;
      reqMiss_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      action_q  <= action_d;
      reqMiss_q <= reqMiss_d;
      if (state_q == IDLE && io.cpu_req) begin
        reqRw_q    <= io.cpu_rw;
        reqIndex_q <= io.cpu_index;
        reqTag_q   <= io.cpu_tag;
      end
    end
  end

  // Next-state logic, Moore outputs and line-update requests
  always_comb begin
    state_d      = state_q;
    action_d     = action_q;
    reqMiss_d    = reqMiss_q;
    victimClear  = 1'b0;
    commitLine   = 1'b0;
    commitState  = curState;
    io.cpu_ready = 1'b0;
    io.bus_req   = 1'b0;
    io.writeback = 1'b0;
    io.acao      = ACT_NULL;
    io.bus_addr  = '0;

    unique case (state_q)
      IDLE: begin
        if (io.cpu_req) state_d = LOOKUP;
      end

      LOOKUP: begin
        reqMiss_d = !hit;
        if (hit) begin
          if (!reqRw_q || curState == ST_EXC) begin
            state_d = DONE;
          end else begin
            action_d = ACT_INVALIDATE;
            state_d  = BUS_REQ;
          end
        end else begin
          action_d = reqRw_q ? ACT_WRITE_MISS : ACT_READ_MISS;
          state_d  = (curState == ST_EXC) ? WB_REQ : BUS_REQ;
        end
      end

      WB_REQ: begin
        io.bus_req   = 1'b1;
        io.writeback = 1'b1;
        io.bus_addr  = {lineTag_q[reqIndex_q], reqIndex_q};
        if (io.bus_grant) state_d = WB_WAIT;
      end

      WB_WAIT: begin
        if (io.bus_done) begin
          victimClear = 1'b1;
          state_d     = BUS_REQ;
        end
      end

      BUS_REQ: begin
        io.bus_req  = 1'b1;
        io.acao     = action_q;
        io.bus_addr = {reqTag_q, reqIndex_q};
        if (io.bus_grant) begin
          state_d = (action_q == ACT_INVALIDATE) ? DONE : BUS_WAIT;
        end else if (action_q == ACT_INVALIDATE &&
                     (snoopInvalidatesReq || curState == ST_INV)) begin
          action_d  = ACT_WRITE_MISS;
          reqMiss_d = 1'b1;
        end
      end

      BUS_WAIT: begin
        if (io.bus_done) state_d = DONE;
      end

      DONE: begin
        io.cpu_ready = 1'b1;
        state_d      = IDLE;
        if (reqRw_q) begin
          commitLine  = 1'b1;
          commitState = ST_EXC;
        end else if (reqMiss_q) begin
          commitLine  = 1'b1;
          commitState = ST_SHR;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Line state/tag array; controller updates are ordered after snoop
  // updates so the controller wins on a same-index collision
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) begin
        lineState_q[i] <= ST_INV;
        lineTag_q[i]   <= '0;
      end
    end else begin
      if (io.snoop_valid) lineState_q[io.snoop_index] <= io.snoop_state;
      if (victimClear) lineState_q[reqIndex_q] <= ST_INV;
      if (commitLine) begin
        lineState_q[reqIndex_q] <= commitState;
        lineTag_q[reqIndex_q]   <= reqTag_q;
      end
    end
  end

endmodule

// File: tb/tb_cpu_coherence_ctrl.sv
// Directed testbench for cpu_coherence_ctrl: cold read, upgrade, dirty
// eviction, snoop race, commit collision and reset in mid-miss.
module tb_cpu_coherence_ctrl;

  localparam int INDEX_W = 2;
  localparam int TAG_W   = 4;

  logic clock;
  logic reset_n;

  int assertCount = 0;
  int failCount   = 0;

  cpu_coherence_ctrl_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) ifc ();

  cpu_coherence_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (ifc)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkLine(input string tag, input int idx, input logic [1:0] expState,
                           input logic [3:0] expTag);
    checkOutput({tag, "_state"}, 32'(dut.lineState_q[idx]), 32'(expState));
    checkOutput({tag, "_tag"}, 32'(dut.lineTag_q[idx]), 32'(expTag));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(ifc.cpu_ready), 32'd0);
    checkOutput({tag, "_busreq"}, 32'(ifc.bus_req), 32'd0);
    checkOutput({tag, "_wb"}, 32'(ifc.writeback), 32'd0);
    checkOutput({tag, "_acao"}, 32'(ifc.acao), 32'd3);
    checkOutput({tag, "_addr"}, 32'(ifc.bus_addr), 32'd0);
  endtask

  // Presents a request, lets IDLE sample it, then drops it; returns in LOOKUP
  task automatic applyStimulus(input logic rw, input logic [1:0] idx, input logic [3:0] tag);
    ifc.cpu_req   = 1'b1;
    ifc.cpu_rw    = rw;
    ifc.cpu_index = idx;
    ifc.cpu_tag   = tag;
    cycle();
    ifc.cpu_req = 1'b0;
  endtask

  task automatic pulseGrant();
    ifc.bus_grant = 1'b1;
    cycle();
    ifc.bus_grant = 1'b0;
  endtask

  task automatic pulseDone();
    ifc.bus_done = 1'b1;
    cycle();
    ifc.bus_done = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    ifc.cpu_req     = 1'b0;
    ifc.cpu_rw      = 1'b0;
    ifc.cpu_index   = '0;
    ifc.cpu_tag     = '0;
    ifc.bus_grant   = 1'b0;
    ifc.bus_done    = 1'b0;
    ifc.snoop_valid = 1'b0;
    ifc.snoop_index = '0;
    ifc.snoop_state = '0;

    #1;
    checkIdleOutputs("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    checkLine("reset_line1", 1, 2'b00, 4'd0);

    $display("[TB] cold read idx 1 tag 3");
    applyStimulus(1'b0, 2'd1, 4'd3);
    checkOutput("cold_lookup_busreq", 32'(ifc.bus_req), 32'd0);
    cycle();
    checkOutput("cold_busreq", 32'(ifc.bus_req), 32'd1);
    checkOutput("cold_acao", 32'(ifc.acao), 32'd0);
    checkOutput("cold_addr", 32'(ifc.bus_addr), 32'h0D);
    cycle();
    checkOutput("cold_held_acao", 32'(ifc.acao), 32'd0);
    pulseGrant();
    checkOutput("cold_wait_busreq", 32'(ifc.bus_req), 32'd0);
    checkOutput("cold_wait_acao", 32'(ifc.acao), 32'd3);
    cycle();
    checkOutput("cold_wait_ready", 32'(ifc.cpu_ready), 32'd0);
    pulseDone();
    checkOutput("cold_done_ready", 32'(ifc.cpu_ready), 32'd1);
    cycle();
    checkOutput("cold_idle_ready", 32'(ifc.cpu_ready), 32'd0);
    checkLine("cold_line1", 1, 2'b01, 4'd3);

    $display("[TB] repeat read hit");
    applyStimulus(1'b0, 2'd1, 4'd3);
    checkOutput("hit_lookup_ready", 32'(ifc.cpu_ready), 32'd0);
    cycle();
    checkOutput("hit_ready", 32'(ifc.cpu_ready), 32'd1);
    checkOutput("hit_busreq", 32'(ifc.bus_req), 32'd0);
    cycle();

    $display("[TB] stray grant and done in IDLE");
    ifc.bus_grant = 1'b1;
    ifc.bus_done  = 1'b1;
    cycle();
    ifc.bus_grant = 1'b0;
    ifc.bus_done  = 1'b0;
    checkOutput("stray_busreq", 32'(ifc.bus_req), 32'd0);
    checkOutput("stray_ready", 32'(ifc.cpu_ready), 32'd0);

    $display("[TB] upgrade write idx 1 tag 3");
    applyStimulus(1'b1, 2'd1, 4'd3);
    cycle();
    checkOutput("upg_acao", 32'(ifc.acao), 32'd1);
    checkOutput("upg_addr", 32'(ifc.bus_addr), 32'h0D);
    cycle();
    checkOutput("upg_held_acao", 32'(ifc.acao), 32'd1);
    pulseGrant();
    checkOutput("upg_ready", 32'(ifc.cpu_ready), 32'd1);
    checkOutput("upg_busreq", 32'(ifc.bus_req), 32'd0);
    cycle();
    checkLine("upg_line1", 1, 2'b10, 4'd3);
    applyStimulus(1'b1, 2'd1, 4'd3);
    cycle();
    checkOutput("whit_ready", 32'(ifc.cpu_ready), 32'd1);
    checkOutput("whit_busreq", 32'(ifc.bus_req), 32'd0);
    cycle();

    $display("[TB] dirty eviction on idx 2");
    applyStimulus(1'b1, 2'd2, 4'd5);
    cycle();
    checkOutput("wmiss_acao", 32'(ifc.acao), 32'd2);
    pulseGrant();
    pulseDone();
    cycle();
    checkLine("wmiss_line2", 2, 2'b10, 4'd5);
    applyStimulus(1'b0, 2'd2, 4'd6);
    cycle();
    checkOutput("evict_wb", 32'(ifc.writeback), 32'd1);
    checkOutput("evict_busreq", 32'(ifc.bus_req), 32'd1);
    checkOutput("evict_acao", 32'(ifc.acao), 32'd3);
    checkOutput("evict_addr", 32'(ifc.bus_addr), 32'h16);
    cycle();
    checkOutput("evict_held_wb", 32'(ifc.writeback), 32'd1);
    pulseGrant();
    checkOutput("evict_wait_wb", 32'(ifc.writeback), 32'd0);
    checkOutput("evict_wait_busreq", 32'(ifc.bus_req), 32'd0);
    pulseDone();
    checkOutput("refill_acao", 32'(ifc.acao), 32'd0);
    checkOutput("refill_addr", 32'(ifc.bus_addr), 32'h1A);
    checkOutput("refill_wb", 32'(ifc.writeback), 32'd0);
    checkOutput("victim_cleared", 32'(dut.lineState_q[2]), 32'd0);
    pulseGrant();
    pulseDone();
    checkOutput("refill_ready", 32'(ifc.cpu_ready), 32'd1);
    cycle();
    checkLine("refill_line2", 2, 2'b01, 4'd6);

    $display("[TB] snoop race on idx 0");
    applyStimulus(1'b0, 2'd0, 4'd7);
    cycle();
    pulseGrant();
    pulseDone();
    cycle();
    checkLine("race_setup_line0", 0, 2'b01, 4'd7);
    applyStimulus(1'b1, 2'd0, 4'd7);
    cycle();
    checkOutput("race_pre_acao", 32'(ifc.acao), 32'd1);
    ifc.snoop_valid = 1'b1;
    ifc.snoop_index = 2'd0;
    ifc.snoop_state = 2'b00;
    cycle();
    ifc.snoop_valid = 1'b0;
    checkOutput("race_post_acao", 32'(ifc.acao), 32'd2);
    checkOutput("race_post_busreq", 32'(ifc.bus_req), 32'd1);
    pulseGrant();
    checkOutput("race_wait_ready", 32'(ifc.cpu_ready), 32'd0);
    pulseDone();
    checkOutput("race_ready", 32'(ifc.cpu_ready), 32'd1);
    cycle();
    checkLine("race_line0", 0, 2'b10, 4'd7);

    $display("[TB] commit collision on idx 3");
    applyStimulus(1'b1, 2'd3, 4'd9);
    cycle();
    pulseGrant();
    pulseDone();
    checkOutput("coll_ready", 32'(ifc.cpu_ready), 32'd1);
    ifc.snoop_valid = 1'b1;
    ifc.snoop_index = 2'd3;
    ifc.snoop_state = 2'b00;
    cycle();
    ifc.snoop_valid = 1'b0;
    checkLine("coll_line3", 3, 2'b10, 4'd9);

    $display("[TB] snoop downgrade while idle");
    ifc.snoop_valid = 1'b1;
    ifc.snoop_index = 2'd1;
    ifc.snoop_state = 2'b01;
    cycle();
    ifc.snoop_valid = 1'b0;
    checkLine("snoop_line1", 1, 2'b01, 4'd3);

    $display("[TB] reset during BUS_WAIT");
    applyStimulus(1'b0, 2'd2, 4'd1);
    cycle();
    checkOutput("rst_pre_acao", 32'(ifc.acao), 32'd0);
    pulseGrant();
    #2;
    reset_n = 1'b0;
    #1;
    checkIdleOutputs("rst_mid");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rst_line%0d", i), 32'(dut.lineState_q[i]), 32'd0);
    end
    cycle();
    reset_n = 1'b1;
    pulseDone();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_noready%0d", i), 32'(ifc.cpu_ready), 32'd0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
